// File: rtl/ps2_key_decoder_if.sv
// ps2_key_decoder_if: scan-code input and key-event output bundle of the PS/2 key decoder
// master drives sc_data/sc_valid (receiver side) plus key_ready/ovf_clr (consumer side)
// slave (decoder) drives key_valid, key_code, key_ascii, key_break, key_ext, overflow
interface ps2_key_decoder_if;
  logic [7:0] sc_data;
  logic       sc_valid;
  logic       key_ready;
  logic       ovf_clr;
  logic       key_valid;
  logic [7:0] key_code;
  logic [7:0] key_ascii;
  logic       key_break;
  logic       key_ext;
  logic       overflow;
  modport master (
    output sc_data, sc_valid, key_ready, ovf_clr,
    input  key_valid, key_code, key_ascii, key_break, key_ext, overflow
  );
  modport slave (
    input  sc_data, sc_valid, key_ready, ovf_clr,
    output key_valid, key_code, key_ascii, key_break, key_ext, overflow
  );
endinterface

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: PS/2 Set-2 scan-code parser with show-ahead key-event FIFO
// clk, rst_n (async active-low); bus: ps2_key_decoder_if.slave
//   in : sc_data/sc_valid byte strobe, key_ready pop, ovf_clr
//   out: key_valid, key_code, key_ascii, key_break, key_ext (FIFO head), overflow (sticky)
// Optional macro PS2_KEY_SHIFT_EN: shift/caps tracking for uppercase letters
module ps2_key_decoder #(
  parameter int FIFO_DEPTH = 8
) (
  input logic clk,
  input logic rst_n,
  ps2_key_decoder_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, SKIP} state_t;
  state_t state, state_n;
  logic [2:0] cnt, cnt_n;
  logic [7:0] b;
  logic is_ext, is_brk, emit, up, ovf;
  logic [17:0] ev;
  logic [17:0] mem [FIFO_DEPTH];
  logic [AW:0] wptr, rptr;
  logic empty, full, pop, push;
  function automatic logic [7:0] to_ascii(input logic [7:0] c, input logic upper);
    logic [7:0] a;
    case (c)
      8'h1C: a = "a"; 8'h32: a = "b"; 8'h21: a = "c"; 8'h23: a = "d";
      8'h24: a = "e"; 8'h2B: a = "f"; 8'h34: a = "g"; 8'h33: a = "h";
      8'h43: a = "i"; 8'h3B: a = "j"; 8'h42: a = "k"; 8'h4B: a = "l";
      8'h3A: a = "m"; 8'h31: a = "n"; 8'h44: a = "o"; 8'h4D: a = "p";
      8'h15: a = "q"; 8'h2D: a = "r"; 8'h1B: a = "s"; 8'h2C: a = "t";
      8'h3C: a = "u"; 8'h2A: a = "v"; 8'h1D: a = "w"; 8'h22: a = "x";
      8'h35: a = "y"; 8'h1A: a = "z";
      8'h45: a = "0"; 8'h16: a = "1"; 8'h1E: a = "2"; 8'h26: a = "3";
      8'h25: a = "4"; 8'h2E: a = "5"; 8'h36: a = "6"; 8'h3D: a = "7";
      8'h3E: a = "8"; 8'h46: a = "9";
      8'h29: a = 8'h20; 8'h5A: a = 8'h0D; 8'h66: a = 8'h08;
      default: a = 8'h00;
    endcase
    return (upper && a >= "a" && a <= "z") ? a - 8'h20 : a;
  endfunction
  assign b = bus.sc_data;
  assign is_ext = state == EXT || state == EXT_BRK;
  assign is_brk = state == BRK || state == EXT_BRK;
  assign ev = {is_ext, is_brk, b, is_ext ? 8'h00 : to_ascii(b, up)};
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    emit = 1'b0;
    if (bus.sc_valid) begin
      if (state == SKIP) begin
        cnt_n = cnt - 3'd1;
        state_n = cnt == 3'd1 ? IDLE : SKIP;
      end else if (b == 8'hE1) begin
        state_n = SKIP;
        cnt_n = 3'd7;
      end else if (b == 8'hE0) begin
        state_n = is_brk ? EXT_BRK : EXT;
      end else if (b == 8'hF0) begin
        state_n = is_ext ? EXT_BRK : BRK;
      end else begin
        state_n = IDLE;
        emit = !(b inside {8'h00, 8'hFF, 8'hAA, 8'hFA});
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= 3'd0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
    end
`ifdef PS2_KEY_SHIFT_EN
  logic lshift, rshift, caps;
  // modifiers update after the event that carries them has sampled the old state
  assign up = (lshift | rshift) ^ caps;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      lshift <= 1'b0;
      rshift <= 1'b0;
      caps <= 1'b0;
    end else if (emit && !is_ext) begin
      if (b == 8'h12) lshift <= !is_brk;
      if (b == 8'h59) rshift <= !is_brk;
      if (b == 8'h58 && !is_brk) caps <= !caps;
    end
`else
  assign up = 1'b0;
`endif
  assign empty = wptr == rptr;
  assign full = (wptr ^ rptr) == {1'b1, {AW{1'b0}}};
  assign pop = !empty && bus.key_ready;
  // a full FIFO still takes the new event when the head leaves in the same cycle
  assign push = emit && (!full || pop);
  always_ff @(posedge clk)
    if (push) mem[wptr[AW-1:0]] <= ev;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      ovf <= 1'b0;
    end else begin
      if (push) wptr <= wptr + (AW+1)'(1);
      if (pop) rptr <= rptr + (AW+1)'(1);
      ovf <= (emit && !push) ? 1'b1 : bus.ovf_clr ? 1'b0 : ovf;
    end
  assign bus.key_valid = !empty;
  assign bus.overflow = ovf;
  // head fields are forced to zero when empty so stale entries never show
  assign {bus.key_ext, bus.key_break, bus.key_code, bus.key_ascii} = empty ? 18'd0 : mem[rptr[AW-1:0]];
endmodule
